fpga_computer: RTL and testbench

- Top-level of a small 8-bit teaching computer.
- Contains A/B registers, an adder, a 4-bit program counter, an 8-bit memory address register (MAR), a 16x8 RAM, a SEL-driven bus multiplexer, and a manual programming path.
- Also contains an I2C byte-write engine that copies a data byte into an external 24xx-style EEPROM at word address MAR.

---
 rtl/fpga_computer.sv | 261 ++++++++++++++++++++++++++
 tb/tb_fpga_computer.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpga_computer.sv
// 8-bit teaching computer: A/B registers, adder, PC, MAR, 16x8 RAM, bus mux, and an I2C EEPROM byte writer.
// Build option: define I2C_ACK_CHECK_EN to abort on a NACK and skip the EEPROM_DATA update.
module fpga_computer #(
  parameter int unsigned CLK_DIV  = 500,
  parameter logic [6:0]  DEV_ADDR = 7'b1010000
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [3:0] SEL,
  input  logic [7:0] PRGM_IN,
  input  logic       PRGM,
  input  logic       EN,
  input  logic       HLT,
  input  logic       GO,
  input  logic       OE,
  input  logic       WE,
  inout  wire        I2C_SDAT,
  output logic       I2C_SCLK,
  output logic [9:0] CLK_COUNT,
  output logic [5:0] SD_COUNTER,
  output logic       DONE,
  output logic [7:0] CURRENT,
  output logic [7:0] EEPROM_DATA,
  output logic [3:0] COUNT,
  output logic [7:0] BUS_OUT
);

  localparam logic [9:0] HALF      = 10'(CLK_DIV / 2);
  localparam logic [9:0] THREE_Q   = 10'((3 * CLK_DIV) / 4);
  localparam logic [9:0] LAST      = 10'(CLK_DIV - 1);
  localparam logic [7:0] CTRL_BYTE = {DEV_ADDR, 1'b0};

  typedef enum logic [2:0] {
    PH_IDLE,
    PH_START,
    PH_BIT,
    PH_ACK,
    PH_STOP,
    PH_FINISH
  } phase_t;

  logic [7:0] a_reg, b_reg, mar_reg, wdata_reg;
  logic [7:0] ram_reg [16];
  logic [3:0] count_reg;

  logic       go_q_reg, go_prev_reg;
  logic [5:0] sd_reg, sd_next;
  logic [9:0] cc_reg, cc_next;
  logic       done_reg, done_next;
  logic [7:0] current_reg, current_next;
  logic [7:0] eeprom_reg, eeprom_next;
  logic [7:0] mar_snap_reg, mar_snap_next;
  logic [7:0] wdata_snap_reg, wdata_snap_next;
  logic       nack_reg, nack_next;

  logic       start;
  phase_t     phase;
  logic [2:0] bit_rel;
  logic       sda_bit;
  logic       scl;
  logic       sda_release;

  // ---------------- datapath registers ----------------
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      a_reg     <= 8'h00;
      b_reg     <= 8'h00;
      mar_reg   <= 8'h00;
      wdata_reg <= 8'h00;
      count_reg <= 4'h0;
    end else begin
      if (PRGM) begin
        case (SEL)
          4'b0000: a_reg     <= PRGM_IN;
          4'b0001: b_reg     <= PRGM_IN;
          4'b0100: mar_reg   <= PRGM_IN;
          4'b0110: wdata_reg <= PRGM_IN;
          default: ;
        endcase
      end else if (EN && !HLT) begin
        count_reg <= count_reg + 4'd1;
      end
    end
  end

  // RAM words are individually clearable, so each one is its own register.
  generate
    for (genvar gi = 0; gi < 16; gi++) begin : g_ram
      always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
          ram_reg[gi] <= 8'h00;
        end else if (PRGM && SEL == 4'b0101 && mar_reg[3:0] == 4'(gi)) begin
          ram_reg[gi] <= PRGM_IN;
        end
      end
    end
  endgenerate

  always_comb begin
    BUS_OUT = 8'h00;
    if (!OE) begin
      case (SEL)
        4'b0000: BUS_OUT = a_reg;
        4'b0001: BUS_OUT = b_reg;
        4'b0010: BUS_OUT = a_reg + b_reg;
        4'b0011: BUS_OUT = {4'b0000, count_reg};
        4'b0100: BUS_OUT = mar_reg;
        4'b0101: BUS_OUT = ram_reg[mar_reg[3:0]];
        4'b0110: BUS_OUT = wdata_reg;
        4'b0111: BUS_OUT = eeprom_reg;
        default: BUS_OUT = 8'h00;
      endcase
    end
  end

  // ---------------- I2C write engine: state register ----------------
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      go_q_reg       <= 1'b0;
      go_prev_reg    <= 1'b0;
      sd_reg         <= 6'd0;
      cc_reg         <= 10'd0;
      done_reg       <= 1'b0;
      current_reg    <= 8'h00;
      eeprom_reg     <= 8'h00;
      mar_snap_reg   <= 8'h00;
      wdata_snap_reg <= 8'h00;
      nack_reg       <= 1'b0;
    end else begin
      go_q_reg       <= GO;
      go_prev_reg    <= go_q_reg;
      sd_reg         <= sd_next;
      cc_reg         <= cc_next;
      done_reg       <= done_next;
      current_reg    <= current_next;
      eeprom_reg     <= eeprom_next;
      mar_snap_reg   <= mar_snap_next;
      wdata_snap_reg <= wdata_snap_next;
      nack_reg       <= nack_next;
    end
  end

  assign start = go_prev_reg && !go_q_reg && (sd_reg == 6'd0) && !WE;

  // ---------------- I2C write engine: next-state logic ----------------
  always_comb begin
    sd_next         = sd_reg;
    cc_next         = cc_reg;
    done_next       = done_reg;
    current_next    = current_reg;
    eeprom_next     = eeprom_reg;
    mar_snap_next   = mar_snap_reg;
    wdata_snap_next = wdata_snap_reg;
    nack_next       = nack_reg;

    if (start) begin
      sd_next         = 6'd1;
      cc_next         = 10'd0;
      done_next       = 1'b0;
      mar_snap_next   = mar_reg;
      wdata_snap_next = wdata_reg;
      nack_next       = 1'b0;
    end else if (sd_reg == 6'd30) begin
      done_next    = 1'b1;
      sd_next      = 6'd0;
      cc_next      = 10'd0;
      current_next = 8'h00;
      if (!nack_reg) begin
        eeprom_next = wdata_snap_reg;
      end
    end else if (sd_reg != 6'd0) begin
      if (cc_reg == LAST) begin
        cc_next = 10'd0;
        sd_next = sd_reg + 6'd1;
        // CURRENT is loaded as each byte's first bit step begins and held through its ACK.
        case (sd_reg + 6'd1)
          6'd2:    current_next = CTRL_BYTE;
          6'd11:   current_next = mar_snap_reg;
          6'd20:   current_next = wdata_snap_reg;
          default: ;
        endcase
      end else begin
        cc_next = cc_reg + 10'd1;
      end
`ifdef I2C_ACK_CHECK_EN
      if ((sd_reg == 6'd10 || sd_reg == 6'd19 || sd_reg == 6'd28) &&
          cc_reg == THREE_Q && I2C_SDAT) begin
        nack_next = 1'b1;
        sd_next   = 6'd29;
        cc_next   = 10'd0;
      end
`endif
    end
  end

`ifndef I2C_ACK_CHECK_EN
  logic unused_sda;
  assign unused_sda = I2C_SDAT;
`endif

  // ---------------- I2C line decode ----------------
  always_comb begin
    phase = PH_IDLE;
    case (sd_reg)
      6'd0:                phase = PH_IDLE;
      6'd1:                phase = PH_START;
      6'd10, 6'd19, 6'd28: phase = PH_ACK;
      6'd29:               phase = PH_STOP;
      6'd30:               phase = PH_FINISH;
      default:             phase = (sd_reg <= 6'd27) ? PH_BIT : PH_IDLE;
    endcase
  end

  always_comb begin
    if (sd_reg <= 6'd9) begin
      bit_rel = 3'(6'd9 - sd_reg);
    end else if (sd_reg <= 6'd18) begin
      bit_rel = 3'(6'd18 - sd_reg);
    end else begin
      bit_rel = 3'(6'd27 - sd_reg);
    end
    sda_bit = current_reg[bit_rel];
  end

  always_comb begin
    scl         = 1'b1;
    sda_release = 1'b1;
    case (phase)
      PH_START: begin
        scl         = 1'b1;
        sda_release = (cc_reg < HALF);
      end
      PH_BIT: begin
        scl         = (cc_reg >= HALF);
        sda_release = sda_bit;
      end
      PH_ACK: begin
        scl         = (cc_reg >= HALF);
        sda_release = 1'b1;
      end
      PH_STOP: begin
        scl         = (cc_reg >= HALF);
        sda_release = (cc_reg >= THREE_Q);
      end
      default: begin
        scl         = 1'b1;
        sda_release = 1'b1;
      end
    endcase
  end

  assign I2C_SDAT    = sda_release ? 1'bz : 1'b0;
  assign I2C_SCLK    = scl;
  assign CLK_COUNT   = cc_reg;
  assign SD_COUNTER  = sd_reg;
  assign DONE        = done_reg;
  assign CURRENT     = current_reg;
  assign EEPROM_DATA = eeprom_reg;
  assign COUNT       = count_reg;

endmodule

// File: tb/tb_fpga_computer.sv
// Self-checking bench for fpga_computer: datapath checks plus an I2C slave monitor with a byte scoreboard.
module tb_fpga_computer;

  localparam int DIV = 8;

  logic       CLK = 1'b0;
  logic       RESET = 1'b0;
  logic [3:0] SEL = 4'h0;
  logic [7:0] PRGM_IN = 8'h00;
  logic       PRGM = 1'b0;
  logic       EN = 1'b0;
  logic       HLT = 1'b0;
  logic       GO = 1'b1;
  logic       OE = 1'b0;
  logic       WE = 1'b0;
  wire        sda;
  logic       I2C_SCLK;
  logic [9:0] CLK_COUNT;
  logic [5:0] SD_COUNTER;
  logic       DONE;
  logic [7:0] CURRENT;
  logic [7:0] EEPROM_DATA;
  logic [3:0] COUNT;
  logic [7:0] BUS_OUT;

  logic slave_drive = 1'b0;
  logic slave_ack = 1'b1;

  pullup (sda);
  assign sda = slave_drive ? 1'b0 : 1'bz;

  always #5 CLK = ~CLK;

  fpga_computer #(.CLK_DIV(DIV), .DEV_ADDR(7'b1010000)) dut (
    .CLK(CLK), .RESET(RESET), .SEL(SEL), .PRGM_IN(PRGM_IN), .PRGM(PRGM),
    .EN(EN), .HLT(HLT), .GO(GO), .OE(OE), .WE(WE), .I2C_SDAT(sda),
    .I2C_SCLK(I2C_SCLK), .CLK_COUNT(CLK_COUNT), .SD_COUNTER(SD_COUNTER),
    .DONE(DONE), .CURRENT(CURRENT), .EEPROM_DATA(EEPROM_DATA),
    .COUNT(COUNT), .BUS_OUT(BUS_OUT)
  );

  int total = 0;
  int bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
    total++;
    if (got !== expv) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, expv);
    end
  endtask

  // ---------------- I2C slave monitor + scoreboard ----------------
  logic [7:0] exp_q[$];
  logic [7:0] shreg = 8'h00;
  int bitcnt = 0;
  int starts = 0;
  int stops = 0;
  int scl_rises = 0;
  logic scl_prev = 1'b1;
  logic sda_prev = 1'b1;

  always @(negedge CLK) begin
    logic scl_now, sda_now;
    logic [7:0] expb;
    scl_now = I2C_SCLK;
    sda_now = sda;
    if (scl_prev && scl_now && sda_prev && !sda_now) begin
      starts++;
      bitcnt = 0;
    end else if (scl_prev && scl_now && !sda_prev && sda_now) begin
      stops++;
      bitcnt = 0;
    end else if (!scl_prev && scl_now) begin
      scl_rises++;
      if (bitcnt == 8) begin
        bitcnt = 0;
      end else begin
        shreg = {shreg[6:0], sda_now};
        bitcnt++;
        if (bitcnt == 8) begin
          if (exp_q.size() == 0) begin
            check("unexpected_byte", {24'h0, shreg}, 32'hFFFF_FFFF);
          end else begin
            expb = exp_q.pop_front();
            check("i2c_byte", {24'h0, shreg}, {24'h0, expb});
            check("current", {24'h0, CURRENT}, {24'h0, expb});
          end
        end
      end
    end else if (scl_prev && !scl_now) begin
      slave_drive = (bitcnt == 8) && slave_ack;
    end
    scl_prev = scl_now;
    sda_prev = sda_now;
  end

  // ---------------- stimulus helpers ----------------
  task automatic prog(input logic [3:0] s, input logic [7:0] v);
    @(negedge CLK);
    SEL = s;
    PRGM_IN = v;
    PRGM = 1'b1;
    @(negedge CLK);
    PRGM = 1'b0;
  endtask

  task automatic bus_check(input string tag, input logic [3:0] s, input logic [7:0] expv);
    @(negedge CLK);
    SEL = s;
    OE = 1'b0;
    #1;
    check(tag, {24'h0, BUS_OUT}, {24'h0, expv});
  endtask

  task automatic run_write(input bit second_go, output int n);
    @(negedge CLK);
    GO = 1'b0;
    n = 0;
    while (n < 600) begin
      @(posedge CLK);
      n++;
      #1;
      if (n == 1) GO = 1'b1;
      if (n == 3) begin
        check("sd_start", {26'h0, SD_COUNTER}, 32'd1);
        check("cc_start", {22'h0, CLK_COUNT}, 32'd1);
        check("done_clear", {31'h0, DONE}, 32'd0);
      end
      if (second_go && n == 60) GO = 1'b0;
      if (second_go && n == 61) GO = 1'b1;
      if (n > 3 && DONE) break;
    end
    if (!DONE) check("done_timeout", {31'h0, DONE}, 32'd1);
  endtask

  initial begin
    int n, s0, p0, r0;

    // reset
    repeat (2) @(negedge CLK);
    RESET = 1'b1;
    @(negedge CLK);
    check("rst_count", {28'h0, COUNT}, 32'd0);
    check("rst_clk_count", {22'h0, CLK_COUNT}, 32'd0);
    check("rst_sd", {26'h0, SD_COUNTER}, 32'd0);
    check("rst_done", {31'h0, DONE}, 32'd0);
    check("rst_current", {24'h0, CURRENT}, 32'd0);
    check("rst_eeprom", {24'h0, EEPROM_DATA}, 32'd0);
    check("rst_scl", {31'h0, I2C_SCLK}, 32'd1);
    check("rst_sda", {31'h0, sda}, 32'd1);
    bus_check("rst_ram0", 4'b0101, 8'h00);

    // programming path
    prog(4'b0100, 8'h0A);
    prog(4'b0101, 8'hF0);
    bus_check("mar", 4'b0100, 8'h0A);
    bus_check("ram10", 4'b0101, 8'hF0);
    @(negedge CLK);
    OE = 1'b1;
    #1;
    check("oe_off", {24'h0, BUS_OUT}, 32'd0);
    OE = 1'b0;
    prog(4'b0000, 8'hFF);
    prog(4'b0001, 8'h02);
    bus_check("reg_a", 4'b0000, 8'hFF);
    bus_check("reg_b", 4'b0001, 8'h02);
    bus_check("sum", 4'b0010, 8'h01);
    bus_check("unused_sel", 4'b1010, 8'h00);
    $display("datapath: MAR=0a RAM[10]=f0 A=ff B=02");

    // program counter
    @(negedge CLK);
    EN = 1'b1;
    repeat (17) @(negedge CLK);
    EN = 1'b0;
    check("pc_wrap", {28'h0, COUNT}, 32'd1);
    bus_check("pc_bus", 4'b0011, 8'h01);
    @(negedge CLK);
    EN = 1'b1;
    HLT = 1'b1;
    repeat (5) @(negedge CLK);
    EN = 1'b0;
    HLT = 1'b0;
    check("pc_halt", {28'h0, COUNT}, 32'd1);
    SEL = 4'b1000;
    EN = 1'b1;
    PRGM = 1'b1;
    repeat (3) @(negedge CLK);
    EN = 1'b0;
    PRGM = 1'b0;
    check("pc_prgm_block", {28'h0, COUNT}, 32'd1);
    $display("pc: count=%0d", COUNT);

    // EEPROM write with ACK, second GO while busy
    prog(4'b0110, 8'h55);
    bus_check("wdata", 4'b0110, 8'h55);
    slave_ack = 1'b1;
    exp_q.push_back(8'hA0);
    exp_q.push_back(8'h0A);
    exp_q.push_back(8'h55);
    s0 = starts;
    p0 = stops;
    run_write(1'b1, n);
    check("ack_latency", n, 32'd235);
    check("ack_done", {31'h0, DONE}, 32'd1);
    check("ack_eeprom", {24'h0, EEPROM_DATA}, 32'h55);
    check("ack_current_idle", {24'h0, CURRENT}, 32'd0);
    check("ack_starts", starts - s0, 32'd1);
    check("ack_stops", stops - p0, 32'd1);
    check("ack_queue", exp_q.size(), 32'd0);
    bus_check("eeprom_bus", 4'b0111, 8'h55);
    $display("write: addr=0a data=55 cycles=%0d eeprom=%02h", n, EEPROM_DATA);

    // GO ignored while WE=1
    r0 = scl_rises;
    @(negedge CLK);
    WE = 1'b1;
    GO = 1'b0;
    @(negedge CLK);
    GO = 1'b1;
    repeat (20) @(negedge CLK);
    check("we_sd", {26'h0, SD_COUNTER}, 32'd0);
    check("we_scl", scl_rises - r0, 32'd0);
    check("we_done", {31'h0, DONE}, 32'd1);
    WE = 1'b0;
    $display("write blocked: WE=1 sd=%0d", SD_COUNTER);

    // NACK transaction
    prog(4'b0110, 8'h33);
    slave_ack = 1'b0;
    exp_q.push_back(8'hA0);
`ifndef I2C_ACK_CHECK_EN
    exp_q.push_back(8'h0A);
    exp_q.push_back(8'h33);
`endif
    p0 = stops;
    run_write(1'b0, n);
`ifdef I2C_ACK_CHECK_EN
    check("nack_latency", n, 32'd90);
    check("nack_eeprom", {24'h0, EEPROM_DATA}, 32'h55);
`else
    check("nack_latency", n, 32'd235);
    check("nack_eeprom", {24'h0, EEPROM_DATA}, 32'h33);
`endif
    check("nack_done", {31'h0, DONE}, 32'd1);
    check("nack_stops", stops - p0, 32'd1);
    check("nack_queue", exp_q.size(), 32'd0);
    $display("write nack: cycles=%0d eeprom=%02h", n, EEPROM_DATA);

    // reset mid-transaction at step 15
    slave_ack = 1'b1;
    exp_q.push_back(8'hA0);
    exp_q.push_back(8'h0A);
    exp_q.push_back(8'h33);
    @(negedge CLK);
    GO = 1'b0;
    @(negedge CLK);
    GO = 1'b1;
    n = 0;
    while (SD_COUNTER != 6'd15 && n < 400) begin
      @(posedge CLK);
      n++;
      #1;
    end
    check("mid_reached15", {26'h0, SD_COUNTER}, 32'd15);
    #1;
    RESET = 1'b0;
    #1;
    check("mid_scl", {31'h0, I2C_SCLK}, 32'd1);
    check("mid_sda", {31'h0, sda}, 32'd1);
    check("mid_sd", {26'h0, SD_COUNTER}, 32'd0);
    check("mid_done", {31'h0, DONE}, 32'd0);
    check("mid_eeprom", {24'h0, EEPROM_DATA}, 32'd0);
    check("mid_queue", exp_q.size(), 32'd2);
    exp_q.delete();
    @(negedge CLK);
    RESET = 1'b1;
    bus_check("mid_reg_a", 4'b0000, 8'h00);
    $display("abort: reset at step 15");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
